// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - six-digit multiplexed seven-segment driver for two register taps; SEG_DECIMAL_EN selects decimal display
module seg_scan_driver #(
    parameter int DATA_W = 8,
    parameter int SCAN_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in0,
    input  logic [DATA_W-1:0] in1,
    input  logic              freeze,
    output logic [5:0]        an,
    output logic [6:0]        seg,
    output logic              busy
);

`ifdef SEG_DECIMAL_EN
    localparam logic [5:0] BLANK_RST = 6'b110110;
`else
    localparam logic [5:0] BLANK_RST = 6'b100100;
`endif

    logic [DATA_W-1:0] snap0_q, snap0_d;
    logic [DATA_W-1:0] snap1_q, snap1_d;
    logic [SCAN_W-1:0] pre_q, pre_d;
    logic [2:0]        idx_q, idx_d;
    logic [5:0][3:0]   dig_q, dig_d;
    logic [5:0]        blank_q, blank_d;
    logic [5:0]        an_q, an_d;
    logic [6:0]        seg_q, seg_d;
    logic              busy_w;
    logic              load_w;

    function automatic logic [6:0] glyph(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'h0:    g = 7'b1000000;
            4'h1:    g = 7'b1111001;
            4'h2:    g = 7'b0100100;
            4'h3:    g = 7'b0110000;
            4'h4:    g = 7'b0011001;
            4'h5:    g = 7'b0010010;
            4'h6:    g = 7'b0000010;
            4'h7:    g = 7'b1111000;
            4'h8:    g = 7'b0000000;
            4'h9:    g = 7'b0010000;
            4'hA:    g = 7'b0001000;
            4'hB:    g = 7'b0000011;
            4'hC:    g = 7'b1000110;
            4'hD:    g = 7'b0100001;
            4'hE:    g = 7'b0000110;
            default: g = 7'b0001110;
        endcase
        return g;
    endfunction

    // Snapshot load decision, prescaler/index advance and registered scan output from the current digit regs
    always_comb begin
        load_w  = !freeze && !busy_w && ((in0 != snap0_q) || (in1 != snap1_q));
        snap0_d = load_w ? in0 : snap0_q;
        snap1_d = load_w ? in1 : snap1_q;
        pre_d   = pre_q + 1'b1;
        idx_d   = idx_q;
        if (pre_q == {SCAN_W{1'b1}}) begin
            idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
        end
        if (blank_q[idx_q]) begin
            an_d  = 6'h3F;
            seg_d = 7'h7F;
        end else begin
            an_d  = ~(6'b000001 << idx_q);
            seg_d = glyph(dig_q[idx_q]);
        end
    end

`ifdef SEG_DECIMAL_EN
    localparam int CONV_W = DATA_W + 12;

    logic [CONV_W-1:0] conv0_q, conv0_d, conv1_q, conv1_d;
    logic [CONV_W-1:0] step0, step1;
    logic [14:0]       dec0, dec1;
    logic [2:0]        cnt_q, cnt_d;
    logic              busy_q, busy_d;

    // One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift left
    function automatic logic [CONV_W-1:0] dd_step(input logic [CONV_W-1:0] c);
        logic [CONV_W-1:0] a;
        a = c;
        for (int k = 0; k < 3; k++) begin
            if (a[DATA_W+4*k +: 4] >= 4'd5) begin
                a[DATA_W+4*k +: 4] = a[DATA_W+4*k +: 4] + 4'd3;
            end
        end
        return {a[CONV_W-2:0], 1'b0};
    endfunction

    // Returns {blank_h, blank_t, blank_o, h, t, o} with leading zeros suppressed
    function automatic logic [14:0] dec_digits(input logic [CONV_W-1:0] c);
        logic [3:0] h, t, o;
        h = c[CONV_W-1 -: 4];
        t = c[CONV_W-5 -: 4];
        o = c[CONV_W-9 -: 4];
        return {(h == 4'd0), ((h == 4'd0) && (t == 4'd0)), 1'b0, h, t, o};
    endfunction

    assign busy_w = busy_q;

    // Converter: starts on the load edge, shifts once per cycle, commits all six digits when busy falls
    always_comb begin
        conv0_d = conv0_q;
        conv1_d = conv1_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        dig_d   = dig_q;
        blank_d = blank_q;
        step0   = dd_step(conv0_q);
        step1   = dd_step(conv1_q);
        dec0    = dec_digits(step0);
        dec1    = dec_digits(step1);
        if (busy_q) begin
            conv0_d = step0;
            conv1_d = step1;
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
                busy_d       = 1'b0;
                dig_d[2:0]   = dec0[11:0];
                dig_d[5:3]   = dec1[11:0];
                blank_d[2:0] = dec0[14:12];
                blank_d[5:3] = dec1[14:12];
            end
        end else if (load_w) begin
            conv0_d = {12'd0, in0};
            conv1_d = {12'd0, in1};
            cnt_d   = 3'd0;
            busy_d  = 1'b1;
        end
    end

    // Converter state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            conv0_q <= '0;
            conv1_q <= '0;
            cnt_q   <= 3'd0;
            busy_q  <= 1'b0;
        end else begin
            conv0_q <= conv0_d;
            conv1_q <= conv1_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end
`else
    assign busy_w = 1'b0;

    // Hex digits follow the snapshots one edge later; slots 2 and 5 stay blank
    always_comb begin
        dig_d   = {4'h0, snap1_q[7:4], snap1_q[3:0], 4'h0, snap0_q[7:4], snap0_q[3:0]};
        blank_d = 6'b100100;
    end
`endif

    // Snapshot, scan and digit registers
    always_ff @(posedge clk) begin
        if (rst) begin
            snap0_q <= '0;
            snap1_q <= '0;
            pre_q   <= '0;
            idx_q   <= 3'd0;
            dig_q   <= '0;
            blank_q <= BLANK_RST;
            an_q    <= 6'h3F;
            seg_q   <= 7'h7F;
        end else begin
            snap0_q <= snap0_d;
            snap1_q <= snap1_d;
            pre_q   <= pre_d;
            idx_q   <= idx_d;
            dig_q   <= dig_d;
            blank_q <= blank_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign an   = an_q;
    assign seg  = seg_q;
    assign busy = busy_w;

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb/tb_seg_scan_driver.sv - randomized self-checking bench for seg_scan_driver against a time-based display model
module tb_seg_scan_driver;
    localparam int SCAN_W = 2;
`ifdef SEG_DECIMAL_EN
    localparam int BUSY_LEN = 8;
`else
    localparam int BUSY_LEN = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in0 = 8'd0;
    logic [7:0] in1 = 8'd0;
    logic       freeze = 1'b0;
    logic [5:0] an;
    logic [6:0] seg;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [7:0] m0 = 8'd0;
    logic [7:0] m1 = 8'd0;
    logic [6:0] gly [16];

    seg_scan_driver #(.DATA_W(8), .SCAN_W(SCAN_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .in0    (in0),
        .in1    (in1),
        .freeze (freeze),
        .an     (an),
        .seg    (seg),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Each slot is shown for 2^SCAN_W clocks, starting with slot 0 on the first edge after reset
    task automatic check_window(input int n);
        int slot, v, p, dg;
        bit blank;
        logic [5:0] ea;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            slot = ((cyc - 1) / (1 << SCAN_W)) % 6;
            v = (slot < 3) ? int'(m0) : int'(m1);
            p = slot % 3;
`ifdef SEG_DECIMAL_EN
            dg = (p == 0) ? v % 10 : (p == 1) ? (v / 10) % 10 : v / 100;
            blank = (p == 1 && v < 10) || (p == 2 && v < 100);
`else
            dg = (p == 0) ? v % 16 : v / 16;
            blank = (p == 2);
`endif
            ea = blank ? 6'h3F : ~(6'd1 << slot);
            check("scan_an", an, ea);
            if (!blank) check("scan_seg", seg, gly[dg]);
        end
    endtask

    task automatic apply(input logic [7:0] a, input logic [7:0] b, input logic frz);
        int nb, expb;
        nb = 0;
        expb = 0;
        @(negedge clk);
        in0 = a;
        in1 = b;
        freeze = frz;
        if (!frz && (a != m0 || b != m1)) begin
            m0 = a;
            m1 = b;
            expb = BUSY_LEN;
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (busy === 1'b1) nb++;
        end
        check("busy_len", nb, expb);
        check_window(24);
    endtask

    initial begin
        int nb;
        gly = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

        repeat (3) begin
            @(negedge clk);
            check("rst_an", an, 6'h3F);
            check("rst_seg", seg, 7'h7F);
            check("rst_busy", busy, 1'b0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("first_an", an, 6'b111110);
        check("first_seg", seg, gly[0]);
        check_window(30);

        apply(8'hA5, 8'h7F, 1'b0);
        apply(8'h12, 8'h7F, 1'b0);
        apply(8'h34, 8'h7F, 1'b1);
        apply(8'h34, 8'h7F, 1'b0);
        apply(8'h00, 8'h00, 1'b0);
        apply(8'hFF, 8'hFF, 1'b0);
        apply(8'd7, 8'd255, 1'b0);

        // Reset four cycles into a conversion, then reload the unchanged inputs
        @(negedge clk);
        in0 = 8'd200;
        in1 = 8'd99;
        m0 = 8'd200;
        m1 = 8'd99;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", busy, 1'b0);
        check("midrst_an", an, 6'h3F);
        check("midrst_seg", seg, 7'h7F);
        rst = 1'b0;
        nb = 0;
        @(negedge clk);
        check("rel_an", an, 6'b111110);
        check("rel_seg", seg, gly[0]);
        if (busy === 1'b1) nb++;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            if (busy === 1'b1) nb++;
        end
        check("rel_busy_len", nb, BUSY_LEN);
        check_window(24);

        for (int r = 0; r < 6; r++) begin
            apply(8'($urandom), 8'($urandom), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Display back-end for the 8-bit single-cycle processor. Consumes the two architectural register values exported by the register file (its `output0`/`output1` taps) and time-multiplexes them onto a 6-digit common-anode seven-segment display. Sits directly downstream of the register file; it is purely observational and has no path back into the datapath.

## Interface
- `DATA_W`, 8, width of each monitored register value; only 8 is supported.
- `SCAN_W`, 16, width of the refresh prescaler; the display advances one digit per 2^SCAN_W clocks.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  reset; **synchronous, active-high**.
- `in0`  in  DATA_W  value of register 0 (from the register file `output0`).
- `in1`  in  DATA_W  value of register 1 (from the register file `output1`).
- `freeze`  in  1  while high, the snapshot is held and input changes are ignored.
- `an`  out  6  digit enables, active-low, one-hot-low; digits 0–2 show `in0`, digits 3–5 show `in1` (LS digit lowest index).
- `seg`  out  7  segments {g,f,e,d,c,b,a}, active-low.
- `busy`  out  1  conversion in progress (decimal build only; tied 0 otherwise).

## Operation
- Snapshot: `snap0`/`snap1` registers. On any edge with `freeze`=0, `busy`=0, and (`in0`≠`snap0` or `in1`≠`snap1`), both snapshots load from the inputs. This edge is the load edge.
- Digit registers d0..d5 (4 bits each) plus blank flags feed the scan mux. They change atomically, so the display never shows a partially updated value.
- Hex build: d0/d1 = `snap0` low/high nibble, d3/d4 = `snap1` low/high nibble. Digits 2 and 5 are always blank. Digit regs update on the edge after the load edge.
- Scan: the prescaler counts up every clock. When it equals all ones, the digit index advances 0→1→…→5→0.
  - `an`/`seg` are registered and updated together from the current index.
  - A blank digit drives `an`=6'h3F for its slot.
- Glyphs: 0–9 and A–F, standard hex patterns, e.g. '0'=7'b1000000, '1'=7'b1111001, '2'=7'b0100100, '5'=7'b0010010, '7'=7'b1111000, 'A'=7'b0001000, 'F'=7'b0001110.
- `freeze` raised mid-conversion does not abort the conversion. It only blocks the next load.

## Timing
- Reset values:
  - `an`=6'h3F, `seg`=7'h7F, `busy`=0.
  - prescaler=0, index=0, snapshots=0.
  - Digits show 0 per build rules (hex: '0' on d0, d1, d3, d4; decimal: '0' on d0 and d3 only, others blanked).
- First clock after reset release drives digit 0 (`an`=6'b111110).
- Hex latency: input change sampled at load edge E; digit regs valid after E+1; visible when that digit's slot next scans.
- Simultaneous load and scan advance: the scan uses the old digit regs that cycle. No glitch is allowed.
- Reset mid-conversion: `busy` drops on that edge, no digit update occurs, and all state returns to reset values.
- Index wraps 5→0 with no idle slot.

## Configuration
- `SEG_DECIMAL_EN` defined: decimal display.
  - The load edge starts a sequential double-dabble converter on both snapshots in parallel, one shift per cycle.
  - `busy`=1 for exactly the 8 cycles after the load edge. d0..d5 (ones/tens/hundreds per register) update on the edge where `busy` falls.
  - Input changes during `busy` are ignored. The first non-busy edge compares and reloads the then-current values.
  - Leading-zero suppression: hundreds blank if 0; tens blank if hundreds and tens are both 0; ones always shown.
- Undefined: hex build as described, converter absent, `busy` tied 0.

## Test plan
- Reset with `SCAN_W`=2, hex build, `in0`=`in1`=0.
  - During reset: `an`=6'h3F, `seg`=7'h7F.
  - After release: digits 0, 1, 3, 4 show '0' (7'b1000000); slots 2 and 5 drive `an`=6'h3F.
- Hex build, `in0`=8'hA5, `in1`=8'h7F.
  - Digit 0 '5', digit 1 'A', digit 3 'F', digit 4 '7'.
  - Index wraps 5→0 every 24 clocks.
- Decimal build, `in1`=8'd255.
  - `busy` high 8 cycles.
  - Digits 3/4/5 = '5','5','2', appearing only after `busy` falls.
- Decimal build, `in0`=8'd7: digit 0 '7'; digits 1 and 2 blank (`an`=6'h3F in those slots).
- `freeze`=1, then `in0` changes 8'h12→8'h34: display keeps '2','1'. Release `freeze`: a load occurs on the next edge and the display shows '4','3'.
- Decimal build, `rst` asserted at conversion cycle 4:
  - `busy`=0 next cycle, digits revert to reset state.
  - After release, unchanged nonzero inputs trigger a fresh 8-cycle conversion.
